// File: rtl/bus_device_endpoint.sv
// Device-side bus endpoint: a TX FIFO feeding the bus and an RX FIFO with ID filtering.
// Define BUS_EP_STATS_EN to add the tx_sent/rx_recv traffic counters.
module bus_device_endpoint #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [7:0]                 tx_dest,
  input  logic [pckg_sz-9:0]         tx_payload,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_bcast,
  output logic [$clog2(depth):0]     tx_count,
  output logic [$clog2(depth):0]     rx_count,
  output logic [7:0]                 rx_drop,
  output logic [2:0]                 err
`ifdef BUS_EP_STATS_EN
  ,
  output logic [15:0]                tx_sent,
  output logic [15:0]                rx_recv
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;

  logic       tx_wr;
  logic       tx_rd;
  logic       rx_wr;
  logic       rx_rd;
  logic [7:0] push_dest;
  logic       push_match;
  logic       rx_full;
  logic       push_overflow;
  logic       push_misroute;
  logic       push_drop;

  // Handshake qualifiers depend only on registered occupancy, never on pop/push/rx_ready paths to outputs.
  always_comb begin
    tx_ready      = (tx_count != FULL);
    pndng         = (tx_count != '0);
    rx_valid      = (rx_count != '0);
    rx_full       = (rx_count == FULL);
    tx_wr         = tx_valid && tx_ready;
    tx_rd         = pop && pndng;
    push_dest     = D_push[pckg_sz-1 -: 8];
    push_match    = (push_dest == id) || (push_dest == broadcast);
    rx_wr         = push && push_match && !rx_full;
    rx_rd         = rx_ready && rx_valid;
    push_overflow = push && push_match && rx_full;
    push_misroute = push && !push_match;
    push_drop     = push_overflow || push_misroute;
  end

  always_comb begin
    D_pop    = pndng    ? tx_mem[tx_rd_ptr] : '0;
    rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;
    rx_bcast = rx_valid && (rx_data[pckg_sz-1 -: 8] == broadcast);
  end

  // Storage arrays carry no reset; stale contents are masked by the occupancy counts.
  always_ff @(posedge clk) begin
    if (reset && tx_wr) begin
      tx_mem[tx_wr_ptr] <= {tx_dest, tx_payload};
    end
    if (reset && rx_wr) begin
      rx_mem[rx_wr_ptr] <= D_push;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_wr) begin
        tx_wr_ptr <= tx_wr_ptr + AW'(1);
      end
      if (tx_rd) begin
        tx_rd_ptr <= tx_rd_ptr + AW'(1);
      end
      case ({tx_wr, tx_rd})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_wr) begin
        rx_wr_ptr <= rx_wr_ptr + AW'(1);
      end
      if (rx_rd) begin
        rx_rd_ptr <= rx_rd_ptr + AW'(1);
      end
      case ({rx_wr, rx_rd})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err     <= '0;
      rx_drop <= '0;
    end else begin
      if (pop && !pndng) begin
        err[0] <= 1'b1;
      end
      if (push_overflow) begin
        err[1] <= 1'b1;
      end
      if (push_misroute) begin
        err[2] <= 1'b1;
      end
      if (push_drop && (rx_drop != 8'hFF)) begin
        rx_drop <= rx_drop + 8'd1;
      end
    end
  end

`ifdef BUS_EP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_sent <= '0;
      rx_recv <= '0;
    end else begin
      if (tx_rd) begin
        tx_sent <= tx_sent + 16'd1;
      end
      if (rx_wr) begin
        rx_recv <= rx_recv + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_device_endpoint.sv
// Directed bench for bus_device_endpoint (id=1) with immediate-assertion checks.
module tb_bus_device_endpoint;

  logic        CLK_100MHZ;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_dest;
  logic [7:0]  tx_payload;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_bcast;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic [7:0]  rx_drop;
  logic [2:0]  err;
`ifdef BUS_EP_STATS_EN
  logic [15:0] tx_sent;
  logic [15:0] rx_recv;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  bus_device_endpoint #(
    .pckg_sz(16), .depth(8), .id(8'h01), .broadcast(8'hFF)
  ) dut (
    .clk(CLK_100MHZ), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_payload(tx_payload),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_bcast(rx_bcast),
    .tx_count(tx_count), .rx_count(rx_count), .rx_drop(rx_drop), .err(err)
`ifdef BUS_EP_STATS_EN
    , .tx_sent(tx_sent), .rx_recv(rx_recv)
`endif
  );

  initial CLK_100MHZ = 1'b0;
  always #5 CLK_100MHZ = ~CLK_100MHZ;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge CLK_100MHZ);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] dest, input logic [7:0] payload);
    tx_valid   = 1'b1;
    tx_dest    = dest;
    tx_payload = payload;
    tick();
    tx_valid   = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] data);
    push   = 1'b1;
    D_push = data;
    tick();
    push   = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  initial begin
    logic [15:0] exp_order [8];
    reset = 1'b0; tx_valid = 1'b0; tx_dest = '0; tx_payload = '0;
    pop = 1'b0; push = 1'b0; D_push = '0; rx_ready = 1'b0;

    // Reset then idle
    tick();
    reset = 1'b1;
    check_output("rst_pndng",    32'(pndng),    32'h0);
    check_output("rst_D_pop",    32'(D_pop),    32'h0);
    check_output("rst_tx_ready", 32'(tx_ready), 32'h1);
    check_output("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("rst_rx_data",  32'(rx_data),  32'h0);
    check_output("rst_rx_bcast", 32'(rx_bcast), 32'h0);
    check_output("rst_err",      32'(err),      32'h0);
    check_output("rst_rx_drop",  32'(rx_drop),  32'h0);

    // Single write, 1-cycle latency, then pop
    apply_stimulus(8'h02, 8'hA5);
    check_output("wr1_pndng", 32'(pndng), 32'h1);
    check_output("wr1_D_pop", 32'(D_pop), 32'h02A5);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check_output("pop1_pndng", 32'(pndng), 32'h0);
    check_output("pop1_D_pop", 32'(D_pop), 32'h0);
    check_output("pop1_err",   32'(err),   32'h0);

    // Fill TX, blocked 9th write, pop+write interplay
    for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h10 + i), 8'(i));
    check_output("full_count", 32'(tx_count), 32'd8);
    check_output("full_ready", 32'(tx_ready), 32'h0);
    apply_stimulus(8'hEE, 8'hEE);
    check_output("ninth_count", 32'(tx_count), 32'd8);
    check_output("ninth_head",  32'(D_pop),    32'h1000);
    pop = 1'b1;
    apply_stimulus(8'hCC, 8'hCC);
    pop = 1'b0;
    check_output("fullpop_count", 32'(tx_count), 32'd7);
    check_output("fullpop_head",  32'(D_pop),    32'h1101);
    check_output("fullpop_ready", 32'(tx_ready), 32'h1);
    pop = 1'b1;
    apply_stimulus(8'hAA, 8'h01);
    pop = 1'b0;
    check_output("popwr_count", 32'(tx_count), 32'd7);
    apply_stimulus(8'hBB, 8'h02);
    check_output("refill_count", 32'(tx_count), 32'd8);
    exp_order = '{16'h1202, 16'h1303, 16'h1404, 16'h1505, 16'h1606, 16'h1707, 16'hAA01, 16'hBB02};
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("drain_tx%0d", i), 32'(D_pop), 32'(exp_order[i]));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    check_output("drain_tx_pndng", 32'(pndng), 32'h0);

    // RX classification
    rx_push(16'h01C3);
    rx_push(16'hFF11);
    rx_push(16'h0512);
    check_output("rx_cls_count", 32'(rx_count), 32'd2);
    check_output("rx_cls_data",  32'(rx_data),  32'h01C3);
    check_output("rx_cls_bcast", 32'(rx_bcast), 32'h0);
    check_output("rx_cls_err",   32'(err),      32'h4);
    check_output("rx_cls_drop",  32'(rx_drop),  32'd1);
    rx_ready = 1'b1;
    tick();
    check_output("rx_cls_data2",  32'(rx_data),  32'hFF11);
    check_output("rx_cls_bcast2", 32'(rx_bcast), 32'h1);
    tick();
    rx_ready = 1'b0;
    check_output("rx_cls_empty", 32'(rx_valid), 32'h0);
    check_output("rx_cls_zero",  32'(rx_data),  32'h0);

    // RX overflow from a clean state
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) rx_push({8'h01, 8'(8'h20 + i)});
    check_output("ovf_count", 32'(rx_count), 32'd8);
    check_output("ovf_drop",  32'(rx_drop),  32'd2);
    check_output("ovf_err",   32'(err),      32'h2);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("drain_rx%0d", i), 32'(rx_data), 32'(16'h0120 + 16'(i)));
      tick();
    end
    rx_ready = 1'b0;
    check_output("drain_rx_valid", 32'(rx_valid), 32'h0);
    check_output("drain_rx_count", 32'(rx_count), 32'd0);

    // Pop while empty, then reset with traffic queued
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check_output("empty_pop_err", 32'(err), 32'h3);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h30, 8'(i));
    rx_push(16'h0140);
    rx_push(16'hFF41);
    check_output("preq_tx", 32'(tx_count), 32'd3);
    check_output("preq_rx", 32'(rx_count), 32'd2);
    reset = 1'b0; pop = 1'b1; push = 1'b1; D_push = 16'h0150;
    tick();
    reset = 1'b1; pop = 1'b0; push = 1'b0;
    check_output("mid_rst_tx",    32'(tx_count), 32'd0);
    check_output("mid_rst_rx",    32'(rx_count), 32'd0);
    check_output("mid_rst_err",   32'(err),      32'h0);
    check_output("mid_rst_pndng", 32'(pndng),    32'h0);
    check_output("mid_rst_drop",  32'(rx_drop),  32'd0);

    // rx_drop saturates at 255
    push = 1'b1; D_push = 16'h0700;
    for (int i = 0; i < 260; i++) tick();
    push = 1'b0;
    check_output("sat_drop", 32'(rx_drop), 32'd255);
    check_output("sat_err",  32'(err),     32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
